tdc_serial_shifter: RTL
=======================

Name: tdc_serial_shifter

Overview:
- Downstream of the I2C register file. Takes a config-byte image plus a start bit and drives the TDC chip's serial configuration port (sck, sda, scapt, reset).
- The image is snapshotted on a rising edge of the start bit. The chip is then reset, all bits are shifted MSB-first and a capture strobe is issued.
- Outputs are active-high. Pad inversion stays in the top level.

Parameters:
- NBYTES, 12: number of config bytes shifted per frame.
- CLK_DIV, 8: clkin cycles per sck half-period (>=1).
- RESET_CYCLES, 16: clkin cycles p_reset is held high before shifting (>=1).

Ports:
- clkin  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start request (register 1 bit 0). Rising edge triggers a frame.
- cfg_data  in  8*NBYTES  config image. Byte k is cfg_data[8k+7:8k]. Byte 0 is shifted first.
- p_sck  out  1  serial clock to chip.
- p_sda  out  1  serial data to chip. Valid before and during p_sck high.
- p_scapt  out  1  capture strobe. Loads the chip shift register into its config latches.
- p_reset  out  1  chip reset.
- busy  out  1  high from frame acceptance until return to IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0.
  - start edge register = 0.
  - Snapshot and counters cleared.
- Reset mid-frame aborts immediately. All outputs go to 0. No done pulse.
- Start detection:
  - start_q registers start every cycle.
  - Edge = start & ~start_q.
  - A held-high start triggers once only.
  - An edge while busy=1 is ignored and not queued.
- IDLE:
  - On edge: snapshot cfg_data, set busy=1, go to RESET next cycle.
  - cfg_data changes after the snapshot cycle do not affect the frame.
- RESET:
  - p_reset=1 for exactly RESET_CYCLES cycles, then go to SHIFT.
- SHIFT (bit counter 0..8*NBYTES-1, bit order byte0[7], byte0[6] ... byte(N-1)[0]):
  - Low phase, CLK_DIV cycles: p_sck=0, p_sda=current bit.
  - High phase, CLK_DIV cycles: p_sck=1, p_sda unchanged.
  - p_sda only changes on the cycle p_sck returns low, giving CLK_DIV cycles of setup and hold.
  - After the last high phase, p_sck=0 and go to CAPTURE.
- CAPTURE:
  - p_sck=0, p_sda=0.
  - p_scapt=1 for CLK_DIV cycles, then 0 for CLK_DIV cycles (gap), then go to DONE.
- DONE:
  - done=1 for one cycle, busy=0 that same cycle.
  - Go to IDLE.
  - An edge present in the DONE cycle is ignored.
- Frame length: edge cycle E. p_reset rises at E+1. done is asserted at E+1+RESET_CYCLES+16*NBYTES*CLK_DIV+2*CLK_DIV.
- Counters:
  - Phase counter width is clog2(CLK_DIV)+1.
  - Bit counter width is clog2(8*NBYTES)+1.
  - Neither wraps: terminal counts are compared explicitly.
- Outputs are registered (no combinational path from inputs to outputs).
- Never assert two of p_reset/p_sck/p_scapt at once.

Optional Feature:
- Macro: TDC_SHIFT_READBACK_EN.
- Enabled:
  - Extra input p_sdo (1 bit), the chip's serial output. Sampled on the last clkin cycle of each p_sck high phase into a NBYTES*8-bit readback register, same bit order.
  - Extra outputs rb_data (8*NBYTES) and rb_mismatch (1).
  - The readback shows the previous frame's contents.
  - rb_mismatch is updated in DONE: 1 if rb_data differs from the previously shifted snapshot. The first frame after reset always compares against 0.
  - rb_data, rb_mismatch and the previous-snapshot register reset to 0.
- Disabled:
  - No p_sdo, rb_data or rb_mismatch ports and no readback logic.
  - Core behaviour is identical.

Test Plan:
- Reset/idle: rst=0 then 1, start=0 for 100 cycles -> all outputs 0, busy=0.
- Basic frame: NBYTES=12, CLK_DIV=8, RESET_CYCLES=16, cfg_data bytes 254,128,7,0,248,3,192,1,128,15,128,12, start 0->1 at cycle E.
  - p_reset high cycles E+1..E+16.
  - 96 sck pulses, each 8 high / 8 low.
  - Bits sampled on sck rising reproduce 0xFE,0x80,... MSB-first.
  - p_scapt high 8 cycles.
  - done at E+1569; busy low the same cycle.
- Snapshot/retrigger:
  - Change last byte 12->11 during SHIFT and pulse start again -> the frame still shifts 12 and no second frame runs.
  - Start held high continuously -> exactly one frame.
- Back-to-back: start low in DONE, rising 1 cycle after IDLE is re-entered -> second frame starts normally with new byte 11.
- Async reset mid-SHIFT: rst low at bit 40 -> outputs 0 within the same cycle, no done. The next start edge runs a full frame from bit 0.
- TDC_SHIFT_READBACK_EN defined, p_sdo driven by a 96-bit chip model:
  - Frame 1 (image A) -> rb_mismatch=1, since the chip's pre-load contents are compared against the reset snapshot.
  - Frame 2 with image A again -> rb_data equals A and rb_mismatch=0.
  - Flip one model bit before frame 3 -> rb_mismatch=1.

Source files
------------

// File: rtl/tdc_serial_shifter.sv
// tdc_serial_shifter: drives the TDC chip serial config port.
// A rising edge on start snapshots cfg_data, pulses the chip reset, shifts
// all 8*NBYTES bits MSB-first (byte 0 first), then issues a capture strobe.
// All outputs are registered and active-high.
// Optional build macro TDC_SHIFT_READBACK_EN adds p_sdo sampling into
// rb_data and an rb_mismatch flag comparing it with the previous snapshot.
module tdc_serial_shifter #(
  parameter int NBYTES       = 12,
  parameter int CLK_DIV      = 8,
  parameter int RESET_CYCLES = 16
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   cfg_data,
  output logic                  p_sck,
  output logic                  p_sda,
  output logic                  p_scapt,
  output logic                  p_reset,
  output logic                  busy,
  output logic                  done
`ifdef TDC_SHIFT_READBACK_EN
  ,
  input  logic                  p_sdo,
  output logic [8*NBYTES-1:0]   rb_data,
  output logic                  rb_mismatch
`endif
);

  localparam int NBITS = 8 * NBYTES;
  localparam int PW    = $clog2(CLK_DIV) + 1;
  localparam int BW    = $clog2(NBITS) + 1;
  localparam int RW    = $clog2(RESET_CYCLES) + 1;
  localparam int IW    = $clog2(NBITS);

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SHIFT, S_CAPT, S_DONE
  } state_t;

  state_t             state, nstate;
  logic               start_q;
  logic               start_edge;
  logic [NBITS-1:0]   snap;
  logic [PW-1:0]      ph_cnt, ph_nx;
  logic [BW-1:0]      bit_cnt, bit_nx;
  logic [RW-1:0]      rst_cnt, rst_nx;
  logic               hi, hi_nx;
  logic [IW-1:0]      sda_idx;

  logic p_sck_nx, p_sda_nx, p_scapt_nx, p_reset_nx, busy_nx, done_nx;

  assign start_edge = start & ~start_q;

  // Bit i of the frame is byte i/8, bit 7-(i%8): flipping the low three
  // bits of the counter maps frame order onto the cfg_data layout.
  assign sda_idx = bit_nx[IW-1:0] ^ IW'(7);

  // Start edge detector and snapshot of the config image on acceptance
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      snap    <= '0;
    end else begin
      start_q <= start;
      if (state == S_IDLE && start_edge) snap <= cfg_data;
    end
  end

  // State and counter registers
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      rst_cnt <= '0;
      hi      <= 1'b0;
    end else begin
      state   <= nstate;
      ph_cnt  <= ph_nx;
      bit_cnt <= bit_nx;
      rst_cnt <= rst_nx;
      hi      <= hi_nx;
    end
  end

  // Next-state and counter sequencing; hi selects the second half-period
  always_comb begin
    nstate = state;
    ph_nx  = ph_cnt;
    bit_nx = bit_cnt;
    rst_nx = rst_cnt;
    hi_nx  = hi;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          nstate = S_RESET;
          rst_nx = '0;
        end
      end
      S_RESET: begin
        if (rst_cnt == RST_LAST) begin
          nstate = S_SHIFT;
          ph_nx  = '0;
          hi_nx  = 1'b0;
          bit_nx = '0;
        end else begin
          rst_nx = rst_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (ph_cnt == PH_LAST) begin
          ph_nx = '0;
          hi_nx = ~hi;
          if (hi) begin
            if (bit_cnt == BIT_LAST) nstate = S_CAPT;
            else                     bit_nx = bit_cnt + 1'b1;
          end
        end else begin
          ph_nx = ph_cnt + 1'b1;
        end
      end
      S_CAPT: begin
        if (ph_cnt == PH_LAST) begin
          ph_nx = '0;
          hi_nx = ~hi;
          if (hi) nstate = S_DONE;
        end else begin
          ph_nx = ph_cnt + 1'b1;
        end
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Output decode from the next state so the pins come straight off flops
  always_comb begin
    p_reset_nx = (nstate == S_RESET);
    p_sck_nx   = (nstate == S_SHIFT) && hi_nx;
    p_sda_nx   = (nstate == S_SHIFT) ? snap[sda_idx] : 1'b0;
    p_scapt_nx = (nstate == S_CAPT) && !hi_nx;
    busy_nx    = (nstate == S_RESET) || (nstate == S_SHIFT) || (nstate == S_CAPT);
    done_nx    = (nstate == S_DONE);
  end

  // Registered outputs
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      p_reset <= 1'b0;
      p_sck   <= 1'b0;
      p_sda   <= 1'b0;
      p_scapt <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      p_reset <= p_reset_nx;
      p_sck   <= p_sck_nx;
      p_sda   <= p_sda_nx;
      p_scapt <= p_scapt_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

`ifdef TDC_SHIFT_READBACK_EN
  logic [NBITS-1:0] prev_snap;
  logic [IW-1:0]    rb_idx;

  assign rb_idx = bit_cnt[IW-1:0] ^ IW'(7);

  // Sample chip output at the end of each sck high phase; compare at DONE
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      rb_data     <= '0;
      rb_mismatch <= 1'b0;
      prev_snap   <= '0;
    end else begin
      if (state == S_SHIFT && hi && ph_cnt == PH_LAST) rb_data[rb_idx] <= p_sdo;
      if (state == S_DONE) begin
        rb_mismatch <= (rb_data != prev_snap);
        prev_snap   <= snap;
      end
    end
  end
`endif

endmodule
